i2c_xfer_seq: RTL and testbench

Host-side transaction sequencer that sits directly upstream of the I2C master engine. Accepts one command at a time (device address, register pointer, direction, byte count), buffers write payload and read results in two small FIFOs, and drives the master's go/rw/N_Byte/dev_add/R_Pointer/dwr inputs while consuming its ready/done/drd/ack_e outputs. Reports per-transfer completion and error to the host.

---
 rtl/i2c_seq_pkg.sv | 32 +++
 rtl/i2c_seq_fifo.sv | 63 ++++++
 rtl/i2c_xfer_seq.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C transaction sequencer.
// States, field widths and error-cause bit positions.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LAUNCH,
    RUN,
    FINISH
  } state_e;

  localparam int BYTE_W = 8;
  localparam int NB_W   = 6;
  localparam int DEV_W  = 7;

  localparam int ERR_ACK = 0;
  localparam int ERR_CNT = 1;
  localparam int ERR_UNF = 2;
  localparam int ERR_OVF = 3;
  localparam int ERR_RNG = 4;
  localparam int ERR_TMO = 5;
  localparam int ERR_W   = 6;

  function automatic logic nb_bad(
    input logic [NB_W-1:0] nb,
    input int              depth
  );
    return (nb == '0) || (int'(nb) > depth);
  endfunction

endpackage

// File: rtl/i2c_seq_fifo.sv
// Byte FIFO with first-word-fall-through read and occupancy count.
// Simultaneous push and pop both take effect; flush empties it.
module i2c_seq_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [BYTE_W-1:0]       din_i,
  input  logic                    pop_i,
  output logic [BYTE_W-1:0]       dout_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q;
  logic [AW-1:0]     rp_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage array; no reset needed, validity tracked by pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem_q[wp_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/i2c_xfer_seq.sv
// Host-side command sequencer in front of the I2C master engine.
// Optional watchdog on LAUNCH/RUN enabled by I2C_SEQ_TIMEOUT_EN.
module i2c_xfer_seq
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 16
`ifdef I2C_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1 << 20
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [DEV_W-1:0]  cmd_dev_add,
  input  logic [7:0]        cmd_ptr,
  input  logic [NB_W-1:0]   cmd_nbyte,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [BYTE_W-1:0] rd_data,
  output logic              busy,
  output logic              xfer_done,
  output logic              xfer_err,
  output logic              go,
  output logic              rw,
  output logic [NB_W-1:0]   N_Byte,
  output logic [DEV_W-1:0]  dev_add,
  output logic [7:0]        R_Pointer,
  output logic [BYTE_W-1:0] dwr,
  input  logic              ready,
  input  logic              done,
  input  logic              ack_e,
  input  logic [BYTE_W-1:0] drd
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [DEV_W-1:0]  dev_q, dev_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [BYTE_W-1:0] dwr_q, dwr_d;
  logic [NB_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]  cause_q, cause_d;
  logic              xerr_q, xerr_d;
  logic [ERR_W-1:0]  err_vec;
  logic              err_now;

  logic              wr_pop, wr_flush, rd_push;
  logic              wr_full, wr_empty, rd_full, rd_empty;
  logic [CW-1:0]     wr_cnt, rd_cnt;
  logic [BYTE_W-1:0] wr_dout;

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0]       tmo_q, tmo_d;
`endif

  i2c_seq_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (wr_flush),
    .push_i  (wr_valid),
    .din_i   (wr_data),
    .pop_i   (wr_pop),
    .dout_o  (wr_dout),
    .full_o  (wr_full),
    .empty_o (wr_empty),
    .cnt_o   (wr_cnt)
  );

  i2c_seq_fifo #(.DEPTH(DEPTH)) u_rd_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (rd_push),
    .din_i   (drd),
    .pop_i   (rd_ready),
    .dout_o  (rd_data),
    .full_o  (rd_full),
    .empty_o (rd_empty),
    .cnt_o   (rd_cnt)
  );

  assign wr_ready  = ~wr_full;
  assign rd_valid  = ~rd_empty;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign go        = (state_q == LAUNCH);
  assign xfer_done = (state_q == FINISH);
  assign xfer_err  = (state_q == FINISH) ? err_now : xerr_q;
  assign rw        = rw_q;
  assign dev_add   = dev_q;
  assign R_Pointer = ptr_q;
  assign N_Byte    = nb_q;
  assign dwr       = dwr_q;

  // Sequencer state and latched command/result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      ptr_q   <= '0;
      nb_q    <= '0;
      dwr_q   <= '0;
      cnt_q   <= '0;
      cause_q <= '0;
      xerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      ptr_q   <= ptr_d;
      nb_q    <= nb_d;
      dwr_q   <= dwr_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      xerr_q  <= xerr_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  // Watchdog counter for the master-owned phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // Next-state, FIFO strobes and error collection.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    ptr_d    = ptr_q;
    nb_d     = nb_q;
    dwr_d    = dwr_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    xerr_d   = xerr_q;
    wr_pop   = 1'b0;
    wr_flush = 1'b0;
    rd_push  = 1'b0;
    err_vec  = cause_q;
    err_vec[ERR_CNT] = (cnt_q != nb_q);
    err_now  = |err_vec;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          dev_d   = cmd_dev_add;
          ptr_d   = cmd_ptr;
          nb_d    = cmd_nbyte;
          cnt_d   = '0;
          cause_d = '0;
          cause_d[ERR_RNG] = nb_bad(cmd_nbyte, DEPTH);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cause_q[ERR_RNG])
          state_d = FINISH;
        else if (rw_q ? (DEPTH - int'(rd_cnt) >= int'(nb_q))
                      : (int'(wr_cnt) >= int'(nb_q)))
          state_d = LAUNCH;
      end
      LAUNCH: begin
        if (!done) state_d = RUN;
      end
      RUN: begin
        if (ack_e) cause_d[ERR_ACK] = 1'b1;
        if (ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (rw_q) begin
            if (rd_full) cause_d[ERR_OVF] = 1'b1;
            else         rd_push = 1'b1;
          end else begin
            if (wr_empty) begin
              cause_d[ERR_UNF] = 1'b1;
            end else begin
              wr_pop = 1'b1;
              dwr_d  = wr_dout;
            end
          end
        end
        if (done) state_d = FINISH;
      end
      FINISH: begin
        xerr_d  = err_now;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef I2C_SEQ_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == LAUNCH || state_q == RUN) begin
      tmo_d = tmo_q + 32'd1;
      if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d  = FINISH;
        wr_flush = 1'b1;
        wr_pop   = 1'b0;
        rd_push  = 1'b0;
        dwr_d    = dwr_q;
        cause_d[ERR_TMO] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed + randomized bench for i2c_xfer_seq.
// Queue-based FIFO model and inline I2C master model.
module tb_i2c_xfer_seq;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev_add = '0;
  logic [7:0] cmd_ptr = '0;
  logic [5:0] cmd_nbyte = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       busy, xfer_done, xfer_err;
  logic       go, rw;
  logic [5:0] N_Byte;
  logic [6:0] dev_add;
  logic [7:0] R_Pointer, dwr;
  logic       ready = 1'b0;
  logic       done = 1'b1;
  logic       ack_e = 1'b0;
  logic [7:0] drd = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] drd_src[$];
  logic [7:0] exp_dwr = '0;

  i2c_xfer_seq #(
    .DEPTH(DEPTH)
`ifdef I2C_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_dev_add(cmd_dev_add),
    .cmd_ptr(cmd_ptr), .cmd_nbyte(cmd_nbyte),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .go(go), .rw(rw), .N_Byte(N_Byte), .dev_add(dev_add),
    .R_Pointer(R_Pointer), .dwr(dwr),
    .ready(ready), .done(done), .ack_e(ack_e), .drd(drd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_go"}, go, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, xfer_done, 0);
    chk({tag, "_err"}, xfer_err, 0);
    chk({tag, "_rw"}, rw, 0);
    chk({tag, "_nbyte"}, N_Byte, 0);
    chk({tag, "_dev"}, dev_add, 0);
    chk({tag, "_ptr"}, R_Pointer, 0);
    chk({tag, "_dwr"}, dwr, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_cmdrdy"}, cmd_ready, 1);
    chk({tag, "_wrrdy"}, wr_ready, 1);
  endtask

  task automatic push_wr(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
    wq.push_back(b);
  endtask

  task automatic send_cmd(input logic r, input logic [6:0] d,
                          input logic [7:0] p, input logic [5:0] n);
    chk("cmd_ready", cmd_ready, 1);
    cmd_rw = r; cmd_dev_add = d; cmd_ptr = p; cmd_nbyte = n;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_go(output bit got);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (go === 1'b1) got = 1;
      else @(negedge clk);
    end
    chk("go_seen", got, 1);
  endtask

  task automatic run_master(input logic r, input logic [6:0] d,
                            input logic [7:0] p, input int nb,
                            input int pulses, input int ack_idx);
    bit got;
    logic e;
    logic [7:0] b;
    wait_go(got);
    if (!got) return;
    chk("f_rw", rw, r);
    chk("f_dev", dev_add, d);
    chk("f_ptr", R_Pointer, p);
    chk("f_nb", N_Byte, nb);
    repeat (2) @(negedge clk);
    chk("go_hold", go, 1);
    done = 1'b0;
    @(negedge clk);
    chk("go_drop", go, 0);
    for (int k = 0; k < pulses; k++) begin
      b = (drd_src.size() > 0) ? drd_src.pop_front() : 8'($urandom);
      ready = 1'b1;
      drd   = b;
      ack_e = (k == ack_idx);
      @(negedge clk);
      ready = 1'b0;
      ack_e = 1'b0;
      if (r) begin
        if (rq.size() < DEPTH) rq.push_back(b);
      end else begin
        if (wq.size() > 0) exp_dwr = wq.pop_front();
        chk("dwr", dwr, exp_dwr);
        chk("f_nb_run", N_Byte, nb);
      end
      @(negedge clk);
    end
    e = (ack_idx >= 0 && ack_idx < pulses) || (pulses != nb);
    done = 1'b1;
    @(negedge clk);
    chk("xfer_done", xfer_done, 1);
    chk("xfer_err", xfer_err, e);
    @(negedge clk);
    chk("done_pulse", xfer_done, 0);
    chk("busy_end", busy, 0);
    chk("err_held", xfer_err, e);
  endtask

  task automatic drain_rd();
    while (rq.size() > 0) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, rq.pop_front());
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    chk("rd_empty", rd_valid, 0);
  endtask

  task automatic range_cmd(input logic [5:0] n);
    bit seen, sg;
    logic e;
    seen = 0; sg = 0; e = 0;
    send_cmd(1'b0, 7'h22, 8'h01, n);
    for (int i = 0; i < 3 && !seen; i++) begin
      sg |= go;
      if (xfer_done === 1'b1) begin
        seen = 1;
        e = xfer_err;
      end else @(negedge clk);
    end
    chk("rng_done", seen, 1);
    chk("rng_err", e, 1);
    chk("rng_nogo", sg, 0);
    @(negedge clk);
    chk("rng_idle", busy, 0);
  endtask

  initial begin
    bit got;
    logic r;
    logic [6:0] d;
    logic [7:0] p;
    int nb, pulses, ai;

    repeat (2) @(negedge clk);
    chk_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    // Directed write of A1,A2,A3.
    push_wr(8'hA1); push_wr(8'hA2); push_wr(8'hA3);
    send_cmd(1'b0, 7'h50, 8'h10, 6'd3);
    run_master(1'b0, 7'h50, 8'h10, 3, 3, -1);

    // Directed read of 5A, C3.
    drd_src.push_back(8'h5A);
    drd_src.push_back(8'hC3);
    send_cmd(1'b1, 7'h51, 8'h20, 6'd2);
    run_master(1'b1, 7'h51, 8'h20, 2, 2, -1);
    drain_rd();

    // Write with NACK seen mid-transfer.
    push_wr(8'h11); push_wr(8'h22);
    send_cmd(1'b0, 7'h3C, 8'h44, 6'd2);
    run_master(1'b0, 7'h3C, 8'h44, 2, 2, 1);

    // Out-of-range byte counts.
    range_cmd(6'd0);
    range_cmd(6'(DEPTH + 1));

    // Write stalls in CHECK until enough payload is buffered.
    push_wr(8'h01); push_wr(8'h02);
    send_cmd(1'b0, 7'h10, 8'h99, 6'd4);
    repeat (8) @(negedge clk);
    chk("stall_go", go, 0);
    chk("stall_busy", busy, 1);
    push_wr(8'h03); push_wr(8'h04);
    run_master(1'b0, 7'h10, 8'h99, 4, 4, -1);

    // Randomized transfers, some with short/long ready counts.
    for (int t = 0; t < 10; t++) begin
      r  = 1'($urandom);
      d  = 7'($urandom);
      p  = 8'($urandom);
      nb = $urandom_range(1, DEPTH - wq.size());
      pulses = nb;
      if ($urandom_range(0, 3) == 0)
        pulses = (nb == 1 || $urandom_range(0, 1) == 1) ? nb + 1 : nb - 1;
      ai = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      if (!r) for (int i = 0; i < nb; i++) push_wr(8'($urandom));
      send_cmd(r, d, p, 6'(nb));
      run_master(r, d, p, nb, pulses, ai);
      if (r) drain_rd();
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master accepts but never finishes.
    push_wr(8'h77);
    send_cmd(1'b0, 7'h0F, 8'h0F, 6'd1);
    wait_go(got);
    done = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (xfer_done === 1'b1) got = 1;
    end
    chk("tmo_done", got, 1);
    chk("tmo_err", xfer_err, 1);
    done = 1'b1;
    wq.delete();
    @(negedge clk);
    chk("tmo_idle", busy, 0);
`endif

    // Reset asserted while RUN is in progress.
    push_wr(8'hE1); push_wr(8'hE2); push_wr(8'hE3);
    send_cmd(1'b0, 7'h66, 8'h77, 6'd3);
    wait_go(got);
    done = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    if (wq.size() > 0) exp_dwr = wq.pop_front();
    chk("pre_rst_dwr", dwr, exp_dwr);
    chk("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1 chk_reset("mid");
    @(negedge clk);
    reset = 1'b1;
    done  = 1'b1;
    wq.delete();
    rq.delete();
    exp_dwr = '0;
    @(negedge clk);

    // Sequencer still usable after reset; leftovers were flushed.
    push_wr(8'h5C);
    send_cmd(1'b0, 7'h2A, 8'h3B, 6'd1);
    run_master(1'b0, 7'h2A, 8'h3B, 1, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
